// File: rtl/mem_block_copier.sv
// Block copier: moves LEN big-endian 16-bit words between byte addresses over a
// single-port memory, one read and one write per word, with a wrapping checksum.
module mem_block_copier #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(2);
  localparam logic [LEN_WIDTH-1:0]  LAST_WORD  = LEN_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [WORD_WIDTH-1:0] buffer;

  // Control strobes depend only on the registered state.
  assign busy      = (state == READ) || (state == WRITE);
  assign done      = (state == DONE);
  assign mem_wr_en = (state == WRITE);
  assign mem_wdata = buffer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      buffer      <= '0;
      checksum    <= '0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= '0;
            if (len != '0) begin
              src_ptr     <= src_addr;
              dst_ptr     <= dst_addr;
              remaining   <= len;
              mem_address <= src_addr;
              state       <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          buffer      <= mem_rdata;
          src_ptr     <= src_ptr + WORD_BYTES;
          mem_address <= dst_ptr;
          state       <= WRITE;
        end
        WRITE: begin
          checksum  <= checksum + buffer;
          dst_ptr   <= dst_ptr + WORD_BYTES;
          remaining <= remaining - LAST_WORD;
          if (remaining == LAST_WORD) begin
            state <= DONE;
          end else begin
            // src_ptr already advanced during READ, so it points at the next word.
            mem_address <= src_ptr;
            state       <= READ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier: a byte-wide memory model, a table of
// copy jobs with hand-computed results, and a reset-abort sequence.
module tb_mem_block_copier;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [7:0]  mem [65536];
  logic [15:0] addr_lo;

  int checks = 0;
  int errors = 0;

  mem_block_copier #(.ADDR_WIDTH(16), .WORD_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Big-endian word at a byte address, wrapping at the top of memory.
  assign addr_lo   = mem_address + 16'd1;
  assign mem_rdata = {mem[mem_address], mem[addr_lo]};

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_address] = mem_wdata[15:8];
      mem[addr_lo]     = mem_wdata[7:0];
    end
  end

  typedef struct {
    string       name;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    int          pre_n;
    logic [63:0] pre;
    logic [15:0] cks;
    logic [63:0] exp;
    int          inject;
  } job_t;

  job_t jobs [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  function automatic logic [63:0] read_bytes(input logic [15:0] base, input int n);
    logic [63:0] acc = '0;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a   = base + 16'(i);
      acc = {acc[55:0], mem[a]};
    end
    return acc;
  endfunction

  task automatic run_job(input job_t j);
    logic [15:0] a;
    int first = 0;
    int bc = 0;
    int wc = 0;
    int dc = 0;
    clear_mem();
    for (int i = 0; i < j.pre_n; i++) begin
      a      = j.src + 16'(i);
      mem[a] = j.pre[8*(j.pre_n-1-i) +: 8];
    end
    @(negedge clock);
    start = 1'b1; src_addr = j.src; dst_addr = j.dst; len = j.len;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) bc++;
      if (mem_wr_en) wc++;
      if (done) begin
        dc++;
        if (first == 0) first = k;
      end
      if (k == j.inject) begin
        start = 1'b1; src_addr = 16'h0000; dst_addr = 16'h0090; len = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (first != 0 && k >= first + 2) break;
      @(negedge clock);
    end
    start = 1'b0;
    check({j.name, " done_cycle"}, 64'(first), 64'(2 * j.len + 1));
    check({j.name, " busy_cycles"}, 64'(bc), 64'(2 * j.len));
    check({j.name, " write_cycles"}, 64'(wc), 64'(j.len));
    check({j.name, " done_pulses"}, 64'(dc), 64'd1);
    check({j.name, " checksum"}, 64'(checksum), 64'(j.cks));
    check({j.name, " dst_bytes"}, read_bytes(j.dst, 2 * j.len), j.exp);
    if (j.inject != 0) check({j.name, " ignored_dst"}, read_bytes(16'h0090, 2), 64'h0);
  endtask

  initial begin
    jobs[0] = '{"basic", 16'h0000, 16'h0010, 8'd3, 6, 64'h000102030405, 16'h0609, 64'h000102030405, 0};
    jobs[1] = '{"len0", 16'h0040, 16'h0050, 8'd0, 0, 64'h0, 16'h0000, 64'h0, 0};
    jobs[2] = '{"wrap", 16'hFFFE, 16'h0020, 8'd2, 4, 64'hABCD0001, 16'hABCE, 64'hABCD0001, 0};
    jobs[3] = '{"overlap", 16'h0000, 16'h0002, 8'd2, 4, 64'h11223344, 16'h2244, 64'h11221122, 0};
    jobs[4] = '{"odd_addr", 16'h0101, 16'h0203, 8'd1, 2, 64'hFF80, 16'hFF80, 64'hFF80, 0};
    jobs[5] = '{"start_ignored", 16'h0000, 16'h0010, 8'd3, 6, 64'h000102030405, 16'h0609, 64'h000102030405, 3};

    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    clear_mem();
    repeat (2) @(negedge clock);
    check("reset_outputs", {busy, done, mem_wr_en, mem_address, mem_wdata, checksum}, 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Abort a len=4 copy while word 2 is being written.
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    @(negedge clock);
    start = 1'b1; src_addr = 16'h0000; dst_addr = 16'h0030; len = 8'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_in_write2", {mem_wr_en, mem_address}, {1'b1, 16'h0032});
    reset = 1'b0;
    #1;
    check("abort_outputs", {busy, done, mem_wr_en, mem_address, mem_wdata, checksum}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_idle", {busy, done, mem_wr_en}, 64'h0);
    check("abort_dst_bytes", read_bytes(16'h0030, 8), 64'h1011000000000000);

    run_job(jobs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Bus initiator for the 16-bit word / byte-addressed memory port (address, wr_en, data_in, data_out).
- On a start pulse, copies LEN big-endian 16-bit words from a source byte address to a destination byte address, one read and one write per word.
- Accumulates a 16-bit wrapping checksum of the words moved.
- Sits between a control block and the memory instance and owns that memory's port while busy.

Parameters:
- ADDR_WIDTH, 16, byte-address width; matches memory address port.
- WORD_WIDTH, 16, data word width; 2 bytes per word.
- LEN_WIDTH, 8, width of word-count input.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- src_addr  input  ADDR_WIDTH  source byte address of the first word.
- dst_addr  input  ADDR_WIDTH  destination byte address of the first word.
- len  input  LEN_WIDTH  number of words to copy.
- busy  output  1  high while a copy is in progress (READ/WRITE states).
- done  output  1  one-cycle pulse when a copy completes.
- checksum  output  WORD_WIDTH  wrapping sum of all words written by the last copy.
- mem_address  output  ADDR_WIDTH  drives the memory address port.
- mem_wr_en  output  1  drives the memory wr_en port.
- mem_wdata  output  WORD_WIDTH  drives the memory data_in port.
- mem_rdata  input  WORD_WIDTH  from the memory data_out port; combinational read of the current address.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, mem_wr_en = 0; mem_address, mem_wdata, checksum = 0; internal pointers, count and buffer = 0.
- Reset asserted mid-copy aborts immediately. Bytes already written stay written; there is no partial-done pulse.
- States: IDLE, READ, WRITE, DONE. Outputs are decoded from registered state and pointers only; there is no combinational path from inputs to outputs.
- IDLE: mem_wr_en=0; mem_address holds its last value.
  - start=1 and len!=0: latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=len; clear checksum; go to READ.
  - start=1 and len==0: clear checksum; go to DONE (no memory access).
- READ: mem_address=src_ptr, mem_wr_en=0.
  - At the clock edge: buffer<=mem_rdata, src_ptr<=src_ptr+2; go to WRITE.
- WRITE: mem_address=dst_ptr, mem_wr_en=1, mem_wdata=buffer.
  - At the clock edge: checksum<=checksum+buffer (mod 2^16), dst_ptr<=dst_ptr+2, remaining<=remaining-1.
  - If remaining==1, go to DONE; else go to READ.
- DONE: done=1, busy=0, mem_wr_en=0 for exactly one cycle, then IDLE.
- Throughput: 2 cycles per word. For len=N>0, busy is high for 2N cycles starting the cycle after the start edge; done pulses in cycle 2N+1.
- start is ignored while busy or in DONE; there is no queuing.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. A word at 0xFFFE uses bytes 0xFFFE and 0xFFFF. Odd addresses are allowed; the word is the byte pair (a, a+1).
- Overlapping regions are always copied in ascending order. When dst > src and the regions overlap, the destination may re-copy data already written; this is defined behaviour.
- checksum holds its value after done until the next accepted start.

Test Plan:
- Preload mem[0..5]=00,01,02,03,04,05. Start src=0, dst=0x10, len=3 -> mem[0x10..0x15]=00..05; busy high 6 cycles; done pulse in cycle 7; checksum=0x0001+0x0203+0x0405=0x0609.
- Start with len=0 -> no mem_wr_en assertion; done pulses in the cycle after start; checksum=0.
- Start src=0xFFFE (preloaded AB,CD), dst=0x0020, len=2 -> 2nd read at 0x0000; mem[0x20..0x23]=AB,CD,00,01; checksum=0xAB+CD plus 0x0001 = 0xABCE.
- Assert start again at cycle 3 of a len=3 copy with different src/dst -> ignored; the original copy completes unchanged with a single done pulse.
- Drop reset during the WRITE of word 2 of a len=4 copy -> all outputs 0 immediately; only word 1 is written at dst; a subsequent start runs normally.
- Overlap: src=0, dst=2, len=2 with mem[0..3]=11,22,33,44 -> mem[2..5]=11,22,11,22; checksum=0x2244.
